// File: rtl/k_and_s_boot_ctrl.sv
// rtl/k_and_s_boot_ctrl.sv - K&S core boot/run sequencer: program load, core release, halt/run-cycle tracking.
// Optional watchdog enabled by defining K_AND_S_WATCHDOG_EN.
module k_and_s_boot_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_rst_n,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] load_ptr;
    logic              run_first;
    logic              halted;
    logic              accept;
    logic              halt_take;
    logic              wd_hit;

    assign accept    = (state == ST_LOAD) && load_valid;
    // The core is still leaving reset on its first RUN cycle, so its halt line is not trusted yet.
    assign halt_take = (state == ST_RUN) && !run_first && cpu_halt;

`ifdef K_AND_S_WATCHDOG_EN
    assign wd_hit = (state == ST_RUN) && (cycle_count == CNT_W'(MAX_CYCLES)) && !halt_take;
`else
    assign wd_hit = 1'b0;
`endif

    assign load_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD) || (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            load_ptr    <= '0;
            cpu_rst_n   <= 1'b0;
            run_first   <= 1'b0;
            halted      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_LOAD;
                        load_ptr    <= '0;
                        cpu_rst_n   <= 1'b0;
                        halted      <= 1'b0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (load_last) begin
                            state     <= ST_RUN;
                            cpu_rst_n <= 1'b1;
                            run_first <= 1'b1;
                        end else if (load_ptr == PTR_MAX) begin
                            state <= ST_DONE;
                            error <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    run_first <= 1'b0;
                    if (wd_hit) begin
                        state     <= ST_DONE;
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end else begin
                        if (cycle_count != CNT_MAX) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (halt_take) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            halted <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A halted core keeps the RAM port so its memory can still be inspected after the run.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (state == ST_LOAD) begin
            ram_addr  = load_ptr;
            ram_wdata = load_data;
            ram_we    = accept;
        end else if ((state == ST_RUN) || ((state == ST_DONE) && halted)) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end
    end

endmodule

// File: tb/tb_k_and_s_boot_ctrl.sv
// tb/tb_k_and_s_boot_ctrl.sv - directed self-checking bench for k_and_s_boot_ctrl.
module tb_k_and_s_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        cpu_rst_n;
    logic        cpu_halt = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic [4:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        error;
    logic        timeout;
    logic [15:0] cycle_count;

    int tests_run = 0;
    int tests_failed = 0;
    int we_cnt = 0;
    int base;

    k_and_s_boot_ctrl #(
        .ADDR_W(5), .DATA_W(16), .CNT_W(16), .MAX_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .cpu_rst_n(cpu_rst_n), .cpu_halt(cpu_halt),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .busy(busy), .done(done), .error(error), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic [4:0] a);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        #1;
        check("ld_we", ram_we, 1);
        check("ld_addr", ram_addr, a);
        check("ld_wdata", ram_wdata, d);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", load_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_count", cycle_count, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: three-word program, core released one cycle after the last accept
        pulse_start();
        check("t1_ready", load_ready, 1);
        check("t1_busy", busy, 1);
        base = we_cnt;
        send(16'h1234, 1'b0, 5'd0);
        check("t1_hold", cpu_rst_n, 0);
        send(16'h5678, 1'b0, 5'd1);
        send(16'hF000, 1'b1, 5'd2);
        check("t1_cpu_rst_n", cpu_rst_n, 1);
        check("t1_we_pulses", we_cnt - base, 3);
        check("t1_ready_run", load_ready, 0);

        // Test 2: halt raised in the 10th RUN cycle
        repeat (9) tick();
        cpu_halt = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 16'hBEEF;
        #1;
        check("t2_mux_we", ram_we, 1);
        check("t2_mux_addr", ram_addr, 7);
        check("t2_mux_data", ram_wdata, 16'hBEEF);
        check("t2_not_done", done, 0);
        tick();
        cpu_halt = 1'b0; cpu_we = 1'b0;
        #1;
        check("t2_done", done, 1);
        check("t2_count", cycle_count, 10);
        check("t2_busy", busy, 0);
        check("t2_ram_we", ram_we, 0);
        check("t2_cpu_held_out", cpu_rst_n, 1);
        check("t2_timeout", timeout, 0);
        tick();
        check("t2_done_held", done, 1);

        // Test 3: 32 words without last overflow the RAM
        pulse_start();
        check("t3_cpu_rst_n", cpu_rst_n, 0);
        check("t3_done_clr", done, 0);
        check("t3_count_clr", cycle_count, 0);
        base = we_cnt;
        for (int i = 0; i < 32; i++) begin
            send(16'(16'hA000 + i), 1'b0, 5'(i));
        end
        check("t3_error", error, 1);
        check("t3_done", done, 1);
        check("t3_cpu_rst_n_end", cpu_rst_n, 0);
        check("t3_busy", busy, 0);
        check("t3_we_pulses", we_cnt - base, 32);
        tick();
        check("t3_no_run", cpu_rst_n, 0);

        // Test 4: load_valid gaps between words
        pulse_start();
        check("t4_error_clr", error, 0);
        base = we_cnt;
        send(16'h0011, 1'b0, 5'd0);
        #1;
        check("t4_gap1_we", ram_we, 0);
        check("t4_gap1_ready", load_ready, 1);
        tick();
        send(16'h0022, 1'b0, 5'd1);
        #1;
        check("t4_gap2_we", ram_we, 0);
        tick();
        send(16'h0033, 1'b0, 5'd2);
        send(16'h0044, 1'b1, 5'd3);
        check("t4_we_pulses", we_cnt - base, 4);
        check("t4_run", cpu_rst_n, 1);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("t4_first_halt_ignored", busy, 1);
        check("t4_first_halt_done", done, 0);

        // Test 5: asynchronous reset mid-RUN and mid-LOAD
        rst_n = 1'b0;
        #1;
        check("t5_async_cpu", cpu_rst_n, 0);
        check("t5_async_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send(16'h1111, 1'b0, 5'd0);
        send(16'h2222, 1'b0, 5'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_ready", load_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        check("t5_count", cycle_count, 0);
        send(16'h3333, 1'b1, 5'd0);
        check("t5_run", cpu_rst_n, 1);

        // Test 6: start during RUN is ignored; watchdog when built in
        repeat (3) tick();
        pulse_start();
        check("t6_start_ign_busy", busy, 1);
        check("t6_start_ign_cpu", cpu_rst_n, 1);
        check("t6_start_ign_count", cycle_count, 4);
`ifdef K_AND_S_WATCHDOG_EN
        for (int i = 0; i < 100 && !done; i++) tick();
        check("t6_done", done, 1);
        check("t6_timeout", timeout, 1);
        check("t6_count", cycle_count, 20);
        check("t6_cpu_rst_n", cpu_rst_n, 0);
`else
        repeat (30) tick();
        check("t6_no_wd_busy", busy, 1);
        check("t6_no_wd_count", cycle_count, 34);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("t6_done", done, 1);
        check("t6_timeout", timeout, 0);
`endif
        pulse_start();
        check("t6_restart_ready", load_ready, 1);
        check("t6_restart_done", done, 0);
        check("t6_restart_cpu", cpu_rst_n, 0);
        send(16'h4444, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
